rpeak_detector_mc: RTL and testbench
====================================

Name: rpeak_detector_mc

Overview:
- Multi-channel R-peak detector and successor to the single-channel ECG algorithm core; it is self-contained.
- NUM_CH ECG channels share one time-multiplexed datapath, with per-channel state held in register arrays.
- Per sample and per channel: moving average, absolute deviation, adaptive threshold with init phase, QRS window, refractory window, RR period.
- Sits between the sample acquisition/demux and the RR reporting logic, and shares the global sample counter i_ctr.

Parameters:
- DATA_WIDTH, 11, signed sample width.
- CTR_WIDTH, 22, sample-counter / RR width.
- NUM_CH, 4, number of channels (>=1).
- NAVG, 16, moving-average length; power of two, >=2.
- INIT_SAMPLES, 256, samples per channel used for threshold initialisation.
- REFRACTORY, 50, per-channel samples ignored after a peak.
- TH_SHIFT, 1, threshold = peak >> TH_SHIFT.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_ce, in, 1, clock enable; low freezes all state.
- i_sample, in, DATA_WIDTH, signed ECG sample.
- i_sample_ch, in, CHW=max(1,$clog2(NUM_CH)), channel index of i_sample.
- i_sample_valid, in, 1, sample present.
- o_ready, out, 1, datapath can accept a sample.
- i_ctr, in, CTR_WIDTH, free-running sample counter.
- o_peak_valid, out, 1, one-cycle pulse: R peak confirmed.
- o_peak_ch, out, CHW, channel of the reported peak.
- o_rpeak_location, out, CTR_WIDTH, i_ctr value at the peak maximum.
- o_rr_valid, out, 1, one-cycle pulse: o_rr_period is new.
- o_rr_period, out, CTR_WIDTH, location minus previous location, same channel.
- o_rr_irregular, out, 1, see Optional Feature.
- o_th_initialised, out, NUM_CH, per-channel threshold-ready flag.
- o_alg_active, out, NUM_CH, per-channel averaging buffer is full.

Behaviour:
- Reset: all outputs 0 except o_ready, which is 1 after reset deassertion.
  - Per-channel sums, fill counters, pointers, states and thresholds clear.
  - The sample buffer RAM is not reset.
  - An in-flight sample is lost.
- Control FSM: IDLE -> CALC -> DECIDE -> IDLE; each transition happens only when i_ce=1.
  - o_ready = (state==IDLE) & i_ce.
  - Accept = i_sample_valid & o_ready. Channel and sample are latched, together with i_ctr.
  - Throughput is one sample per 3 cycles.
  - Outputs register on the DECIDE->IDLE edge, i.e. they are visible 2 cycles after the accept edge.
- i_sample_ch >= NUM_CH: the sample is accepted and then discarded; no state change, no pulse.
- CALC, arithmetic:
  - sum' = sum - old + sample, where old = buf[ch][ptr], or 0 while filling. Sum width is DATA_WIDTH+log2(NAVG).
  - buf[ch][ptr] = sample; ptr wraps modulo NAVG.
  - avg = sum' >>> log2(NAVG).
  - diff = |sample - avg|, unsigned, saturated to 2^(DATA_WIDTH-1)-1.
- Fill: until NAVG samples are seen, diff is forced to 0 and no detection happens. o_alg_active[ch] rises with the NAVG-th sample.
- Per-channel detector states: INIT, SEARCH, QRS, REFR.
  - INIT: tracks max diff over INIT_SAMPLES active samples.
    - On the last sample: thr = max >> TH_SHIFT, o_th_initialised[ch] = 1, go to SEARCH.
  - SEARCH: if diff > thr, go to QRS with pk = diff and loc = latched ctr.
  - QRS: if diff > pk, update pk and loc.
    - If diff <= thr, the peak is confirmed: pulse o_peak_valid, o_rpeak_location = loc.
    - If a previous peak exists: o_rr_period = loc - prev_loc, modulo 2^CTR_WIDTH (counter wrap is therefore correct), and pulse o_rr_valid.
    - prev_loc = loc; thr = (thr + (pk >> TH_SHIFT)) >> 1; rcnt = REFRACTORY; go to REFR.
  - REFR: decrement rcnt per channel sample; when it reaches 0, go to SEARCH. Samples in REFR still update the average.
- Pulses are one cycle wide, cleared the next cycle regardless of i_ce.
- Data outputs hold their values between pulses.

Optional Feature:
- Macro: RPEAK_RR_OUTLIER_EN.
- Defined:
  - Per-channel prev_rr is stored.
  - With o_rr_valid, o_rr_irregular = 1 when a prev_rr exists and |rr - prev_rr| > (prev_rr >> 2).
  - prev_rr is then updated.
- Undefined: no storage; o_rr_irregular is tied to 0.

Test Plan:
- Test configuration: NAVG=4, INIT_SAMPLES=8, REFRACTORY=3, TH_SHIFT=1, NUM_CH=4.
1. Reset, then i_sample_valid held at 1 -> o_ready pattern 1,0,0 repeating; i_rst pulsed mid-CALC -> all outputs 0, and no pulse for the lost sample.
2. ch0 constant 100 for 40 samples -> o_alg_active[0] after the 4th sample, o_th_initialised[0] after the 12th, no o_peak_valid.
3. ch1 baseline 0 with one 40 spike during INIT (diff 30, thr 15), then spike 40 at ctr 1000 and again at ctr 1400 ->
   - o_peak_valid with o_peak_ch=1, location 1000, no rr;
   - then location 1400 with o_rr_period=400 and o_rr_valid.
4. ch0 spikes interleaved with ch2 flat and i_sample_ch=3 noise -> peaks are reported only on ch0; ch2 and ch3 flags are unaffected.
5. Peak at ctr 2^22-100, next at ctr 50 -> o_rr_period=150; a spike during REFR is ignored.
6. With RPEAK_RR_OUTLIER_EN: RR 400 then 420 -> o_rr_irregular=0; then 600 -> 1. Without the macro, the port is always 0.

Source files
------------

// File: rtl/rpeak_detector_mc.sv
// rpeak_detector_mc: multi-channel ECG R-peak detector.
// NUM_CH channels share one datapath driven by a three-state control FSM
// (IDLE -> CALC -> DECIDE). Per-channel moving-average, threshold and
// detector state are held in register arrays indexed by the sample channel.
// Optional build macro: RPEAK_RR_OUTLIER_EN adds per-channel RR history and
// drives o_rr_irregular; without it o_rr_irregular is tied low.

module rpeak_detector_mc #(
  parameter int  DATA_WIDTH   = 11,
  parameter int  CTR_WIDTH    = 22,
  parameter int  NUM_CH       = 4,
  parameter int  NAVG         = 16,
  parameter int  INIT_SAMPLES = 256,
  parameter int  REFRACTORY   = 50,
  parameter int  TH_SHIFT     = 1,
  localparam int CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  input  logic [CHW-1:0]               i_sample_ch,
  input  logic                         i_sample_valid,
  output logic                         o_ready,
  input  logic [CTR_WIDTH-1:0]         i_ctr,
  output logic                         o_peak_valid,
  output logic [CHW-1:0]               o_peak_ch,
  output logic [CTR_WIDTH-1:0]         o_rpeak_location,
  output logic                         o_rr_valid,
  output logic [CTR_WIDTH-1:0]         o_rr_period,
  output logic                         o_rr_irregular,
  output logic [NUM_CH-1:0]            o_th_initialised,
  output logic [NUM_CH-1:0]            o_alg_active
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(NAVG);                     // log2 of averaging length
  localparam int SW = DW + AW;                          // running-sum width
  localparam int XW = DW - 1;                           // saturated |deviation| width
  localparam int FW = $clog2(NAVG + 1);                 // fill counter width
  localparam int IW = (INIT_SAMPLES > 1) ? $clog2(INIT_SAMPLES + 1) : 1;
  localparam int RW = (REFRACTORY > 1) ? $clog2(REFRACTORY + 1) : 1;
  localparam logic [CHW:0] NUM_CH_X = (CHW + 1)'(NUM_CH);

  typedef enum logic [1:0] {C_IDLE, C_CALC, C_DECIDE} ctl_e;
  typedef enum logic [1:0] {D_INIT, D_SEARCH, D_QRS, D_REFR} det_e;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  ctl_e ctl_q, ctl_d;
  logic ready, accept, calc_en, decide_en;

  // Control FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ctl_q <= C_IDLE;
    else       ctl_q <= ctl_d;
  end

  // Control FSM next state; every step waits for the clock enable
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    ctl_d = ctl_q;
    unique case (ctl_q)
      C_IDLE:   if (accept) ctl_d = C_CALC;
      C_CALC:   if (i_ce)   ctl_d = C_DECIDE;
      C_DECIDE: if (i_ce)   ctl_d = C_IDLE;
      default:              ctl_d = C_IDLE;
    endcase
  end

  // Control FSM outputs: handshake and stage enables
  always_comb begin
    ready     = (ctl_q == C_IDLE) && i_ce;
    accept    = ready && i_sample_valid;
    calc_en   = (ctl_q == C_CALC) && i_ce;
    decide_en = (ctl_q == C_DECIDE) && i_ce;
  end

  assign o_ready = ready;

  // ---------------------------------------------------------------------------
  // Accepted-sample latch
  // ---------------------------------------------------------------------------
  logic [DW-1:0]        smp_q;
  logic [CHW-1:0]       ch_q;
  logic [CTR_WIDTH-1:0] ctr_q;
  logic                 ch_ok;
  logic [CHW-1:0]       idx;

  // Capture sample, channel and counter on accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (i_rst) begin
      smp_q <= '0;
      ch_q  <= '0;
      ctr_q <= '0;
    end else if (accept) begin
      smp_q <= i_sample;
      ch_q  <= i_sample_ch;
      ctr_q <= i_ctr;
    end
  end

  // Out-of-range channels are carried through the FSM but touch no state
  assign ch_ok = ({1'b0, ch_q} < NUM_CH_X);
  assign idx   = ch_ok ? ch_q : '0;

  // ---------------------------------------------------------------------------
  // CALC stage: moving average and absolute deviation
  // ---------------------------------------------------------------------------
  logic [DW-1:0] sample_mem [NUM_CH][NAVG];
  logic [SW-1:0] sum_q  [NUM_CH];
  logic [AW-1:0] ptr_q  [NUM_CH];
  logic [FW-1:0] fill_q [NUM_CH];

  logic          filled;
  logic [DW-1:0] old_smp;
  logic [SW-1:0] sum_d;
  logic [DW-1:0] avg;
  logic [DW:0]   dev, mag;
  logic [XW-1:0] diff_calc;

  logic [XW-1:0] diff_q;
  logic          active_q, full_q;

  // Running sum, average and saturated |sample - average|
  always_comb begin
    filled    = (fill_q[idx] == FW'(NAVG));
    old_smp   = filled ? sample_mem[idx][ptr_q[idx]] : '0;
    sum_d     = sum_q[idx] - {{AW{old_smp[DW-1]}}, old_smp} + {{AW{smp_q[DW-1]}}, smp_q};
    avg       = sum_d[SW-1:AW];
    dev       = {smp_q[DW-1], smp_q} - {avg[DW-1], avg};
    mag       = dev[DW] ? (~dev + 1'b1) : dev;
    diff_calc = '0;
    if (filled) diff_calc = (mag > {2'b00, {XW{1'b1}}}) ? {XW{1'b1}} : mag[XW-1:0];
  end

  // Sample ring buffer write
  // NOTE: the buffer RAM has no reset; fill counters keep stale words from ever being read.
  always_ff @(posedge i_clk) begin
    if (calc_en && ch_ok) sample_mem[idx][ptr_q[idx]] <= smp_q;
  end

  // Per-channel averaging state and CALC result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
      diff_q   <= '0;
      active_q <= 1'b0;
      full_q   <= 1'b0;
    end else if (calc_en) begin
      diff_q   <= diff_calc;
      active_q <= ch_ok && filled;
      full_q   <= ch_ok && (filled || (fill_q[idx] == FW'(NAVG - 1)));
      if (ch_ok) begin
        sum_q[idx] <= sum_d;
        ptr_q[idx] <= ptr_q[idx] + 1'b1;
        if (!filled) fill_q[idx] <= fill_q[idx] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DECIDE stage: per-channel detector
  // ---------------------------------------------------------------------------
  det_e                 det_q      [NUM_CH];
  logic [XW-1:0]        thr_q      [NUM_CH];
  logic [XW-1:0]        pk_q       [NUM_CH];
  logic [XW-1:0]        max_q      [NUM_CH];
  logic [CTR_WIDTH-1:0] loc_q      [NUM_CH];
  logic [CTR_WIDTH-1:0] prev_loc_q [NUM_CH];
  logic [RW-1:0]        rcnt_q     [NUM_CH];
  logic [IW-1:0]        icnt_q     [NUM_CH];
  logic [NUM_CH-1:0]    have_prev_q;

  det_e                 det_d;
  logic [XW-1:0]        thr_d, pk_d, max_d, peak_max;
  logic [XW:0]          thr_sum;
  logic [CTR_WIDTH-1:0] loc_d, prev_loc_d, rr_d;
  logic [RW-1:0]        rcnt_d;
  logic [IW-1:0]        icnt_d;
  logic                 have_prev_d, init_done, peak_fire, rr_fire, irr_d;

  // Detector next state for the channel in flight
  always_comb begin
    det_d       = det_q[idx];
    thr_d       = thr_q[idx];
    pk_d        = pk_q[idx];
    max_d       = max_q[idx];
    loc_d       = loc_q[idx];
    prev_loc_d  = prev_loc_q[idx];
    rcnt_d      = rcnt_q[idx];
    icnt_d      = icnt_q[idx];
    have_prev_d = have_prev_q[idx];
    init_done   = 1'b0;
    peak_fire   = 1'b0;
    rr_fire     = 1'b0;
    rr_d        = loc_q[idx] - prev_loc_q[idx];
    peak_max    = (diff_q > max_q[idx]) ? diff_q : max_q[idx];
    thr_sum     = {1'b0, thr_q[idx]} + {1'b0, (pk_q[idx] >> TH_SHIFT)};
    if (ch_ok && active_q) begin
      unique case (det_q[idx])
        D_INIT: begin
          max_d = peak_max;
          if (icnt_q[idx] == IW'(INIT_SAMPLES - 1)) begin
            thr_d     = peak_max >> TH_SHIFT;
            init_done = 1'b1;
            det_d     = D_SEARCH;
          end else begin
            icnt_d = icnt_q[idx] + 1'b1;
          end
        end
        D_SEARCH: begin
          if (diff_q > thr_q[idx]) begin
            det_d = D_QRS;
            pk_d  = diff_q;
            loc_d = ctr_q;
          end
        end
        D_QRS: begin
          if (diff_q > pk_q[idx]) begin
            pk_d  = diff_q;
            loc_d = ctr_q;
          end else if (diff_q <= thr_q[idx]) begin
            peak_fire   = 1'b1;
            rr_fire     = have_prev_q[idx];
            prev_loc_d  = loc_q[idx];
            have_prev_d = 1'b1;
            thr_d       = XW'(thr_sum >> 1);
            rcnt_d      = RW'(REFRACTORY);
            det_d       = D_REFR;
          end
        end
        D_REFR: begin
          if (rcnt_q[idx] <= RW'(1)) begin
            rcnt_d = '0;
            det_d  = D_SEARCH;
          end else begin
            rcnt_d = rcnt_q[idx] - 1'b1;
          end
        end
        default: det_d = D_INIT;
      endcase
    end
  end

  // Per-channel detector state write-back
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        det_q[c]      <= D_INIT;
        thr_q[c]      <= '0;
        pk_q[c]       <= '0;
        max_q[c]      <= '0;
        loc_q[c]      <= '0;
        prev_loc_q[c] <= '0;
        rcnt_q[c]     <= '0;
        icnt_q[c]     <= '0;
      end
      have_prev_q <= '0;
    end else if (decide_en && ch_ok) begin
      det_q[idx]       <= det_d;
      thr_q[idx]       <= thr_d;
      pk_q[idx]        <= pk_d;
      max_q[idx]       <= max_d;
      loc_q[idx]       <= loc_d;
      prev_loc_q[idx]  <= prev_loc_d;
      rcnt_q[idx]      <= rcnt_d;
      icnt_q[idx]      <= icnt_d;
      have_prev_q[idx] <= have_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RR irregularity (optional)
  // ---------------------------------------------------------------------------
`ifdef RPEAK_RR_OUTLIER_EN
  logic [CTR_WIDTH-1:0] prev_rr_q [NUM_CH];
  logic [NUM_CH-1:0]    have_rr_q;
  logic [CTR_WIDTH-1:0] rr_delta;

  // Compare the new RR against the previous one of the same channel
  always_comb begin
    rr_delta = (rr_d >= prev_rr_q[idx]) ? (rr_d - prev_rr_q[idx]) : (prev_rr_q[idx] - rr_d);
    irr_d    = have_rr_q[idx] && (rr_delta > (prev_rr_q[idx] >> 2));
  end

  // RR history update on every reported interval
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) prev_rr_q[c] <= '0;
      have_rr_q <= '0;
    end else if (decide_en && rr_fire) begin
      prev_rr_q[idx] <= rr_d;
      have_rr_q[idx] <= 1'b1;
    end
  end
`else
  assign irr_d = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output registers (updated on the DECIDE -> IDLE edge)
  // ---------------------------------------------------------------------------
  logic                 peak_valid_q, rr_valid_q, rr_irr_q;
  logic [CHW-1:0]       peak_ch_q;
  logic [CTR_WIDTH-1:0] rloc_q, rr_period_q;
  logic [NUM_CH-1:0]    th_init_q, alg_active_q;

  // Pulses last one cycle regardless of i_ce; data outputs hold between pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      peak_valid_q <= 1'b0;
      rr_valid_q   <= 1'b0;
      rr_irr_q     <= 1'b0;
      peak_ch_q    <= '0;
      rloc_q       <= '0;
      rr_period_q  <= '0;
      th_init_q    <= '0;
      alg_active_q <= '0;
    end else begin
      peak_valid_q <= decide_en && peak_fire;
      rr_valid_q   <= decide_en && rr_fire;
      if (decide_en && peak_fire) begin
        peak_ch_q <= idx;
        rloc_q    <= loc_q[idx];
      end
      if (decide_en && rr_fire) begin
        rr_period_q <= rr_d;
        rr_irr_q    <= irr_d;
      end
      if (decide_en && init_done)        th_init_q[idx]    <= 1'b1;
      if (decide_en && ch_ok && full_q)  alg_active_q[idx] <= 1'b1;
    end
  end

  assign o_peak_valid     = peak_valid_q;
  assign o_peak_ch        = peak_ch_q;
  assign o_rpeak_location = rloc_q;
  assign o_rr_valid       = rr_valid_q;
  assign o_rr_period      = rr_period_q;
  assign o_rr_irregular   = rr_irr_q;
  assign o_th_initialised = th_init_q;
  assign o_alg_active     = alg_active_q;

endmodule

// File: tb/tb_rpeak_detector_mc.sv
// Self-checking bench for rpeak_detector_mc (NAVG=4, INIT_SAMPLES=8,
// REFRACTORY=3, TH_SHIFT=1, NUM_CH=4). Expected peaks are queued by the
// stimulus tasks and consumed by an independent output monitor.

module tb_rpeak_detector_mc;

  localparam int DW  = 11;
  localparam int CW  = 22;
  localparam int NCH = 4;
  localparam int CHW = 2;

`ifdef RPEAK_RR_OUTLIER_EN
  localparam bit OUTLIER = 1'b1;
`else
  localparam bit OUTLIER = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ce = 1'b1;
  logic signed [DW-1:0] sample = '0;
  logic [CHW-1:0]       sample_ch = '0;
  logic                 sample_valid = 1'b0;
  logic                 ready;
  logic [CW-1:0]        ctr = '0;
  logic                 peak_valid;
  logic [CHW-1:0]       peak_ch;
  logic [CW-1:0]        rpeak_location;
  logic                 rr_valid;
  logic [CW-1:0]        rr_period;
  logic                 rr_irregular;
  logic [NCH-1:0]       th_init;
  logic [NCH-1:0]       alg_active;

  always #5 clk = ~clk;

  rpeak_detector_mc #(
    .DATA_WIDTH(DW), .CTR_WIDTH(CW), .NUM_CH(NCH), .NAVG(4),
    .INIT_SAMPLES(8), .REFRACTORY(3), .TH_SHIFT(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_sample(sample), .i_sample_ch(sample_ch), .i_sample_valid(sample_valid),
    .o_ready(ready), .i_ctr(ctr),
    .o_peak_valid(peak_valid), .o_peak_ch(peak_ch), .o_rpeak_location(rpeak_location),
    .o_rr_valid(rr_valid), .o_rr_period(rr_period), .o_rr_irregular(rr_irregular),
    .o_th_initialised(th_init), .o_alg_active(alg_active)
  );

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [CW-1:0]  loc;
    logic           rr_v;
    logic [CW-1:0]  rr;
    logic           irr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every peak pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (peak_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_peak", peak_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("peak_ch", peak_ch, mon_e.ch);
          check("peak_loc", rpeak_location, mon_e.loc);
          check("rr_valid", rr_valid, mon_e.rr_v);
          if (mon_e.rr_v) begin
            check("rr_period", rr_period, mon_e.rr);
            check("rr_irregular", rr_irregular, mon_e.irr);
          end
        end
      end else if (rr_valid) begin
        check("rr_without_peak", rr_valid, 0);
      end
    end
  end

  // One sample, waiting (bounded) for o_ready; returns when its outputs are visible
  task automatic send(input logic [CHW-1:0] ch, input int smp, input logic [CW-1:0] c);
    int guard = 0;
    while (!ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check("ready_timeout", ready, 1);
    sample_valid = 1'b1;
    sample       = DW'(smp);
    sample_ch    = ch;
    ctr          = c;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Optionally follow every sample with a flat ch2 sample
  task automatic send_i(input logic [CHW-1:0] ch, input int smp, input logic [CW-1:0] c, input bit inter);
    send(ch, smp, c);
    if (inter) send(2'd2, 50, c);
  endtask

  // Fill (4 zeros) then INIT (one 40 spike, 7 zeros): thr ends at 15
  task automatic train(input logic [CHW-1:0] ch, input bit inter);
    for (int k = 0; k < 12; k++) send_i(ch, (k == 4) ? 40 : 0, CW'(100 + k), inter);
    check("train_th_init", th_init[ch], 1);
  endtask

  // Spike at loc, confirmed on the next zero; optional spike during REFR
  task automatic beat(input logic [CHW-1:0] ch, input logic [CW-1:0] loc, input logic rr_v,
                      input logic [CW-1:0] rr, input logic irr, input bit inter, input bit refr_spike);
    exp_t e;
    e.ch = ch; e.loc = loc; e.rr_v = rr_v; e.rr = rr; e.irr = irr;
    sb_q.push_back(e);
    send_i(ch, 40, loc, inter);
    send_i(ch, 0, loc + 1, inter);
    if (refr_spike) send_i(ch, 40, loc + 2, inter);
    for (int k = 0; k < 4; k++) send_i(ch, 0, loc + CW'(3 + k), inter);
    check("beat_drained", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // 1: ready pattern with valid held high, reset mid-CALC
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sample_valid = 1'b1; sample = 11'sd5; sample_ch = 2'd0; ctr = 22'd7;
    for (int k = 0; k < 5; k++) begin
      check("ready_pattern", ready, pat[k]);
      if (k < 4) @(negedge clk);
    end
    sample_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_rr_valid", rr_valid, 0);
    check("rst_peak_ch", peak_ch, 0);
    check("rst_location", rpeak_location, 0);
    check("rst_rr_period", rr_period, 0);
    check("rst_rr_irregular", rr_irregular, 0);
    check("rst_th_init", th_init, 0);
    check("rst_alg_active", alg_active, 0);

    // 2: constant input activates averaging and threshold, never peaks
    for (int k = 1; k <= 40; k++) begin
      send(2'd0, 100, CW'(k));
      if (k == 3)  check("alg_active_before", alg_active[0], 0);
      if (k == 4)  check("alg_active_at4", alg_active[0], 1);
      if (k == 11) check("th_init_before", th_init[0], 0);
      if (k == 12) check("th_init_at12", th_init[0], 1);
    end
    check("flat_no_peak", sb_q.size(), 0);

    // 3 + 6: ch1 peaks at 1000, 1400, 1820, 2420 (RR 400, 420, 600)
    do_reset();
    train(2'd1, 1'b0);
    check("ch1_alg_active", alg_active, 4'b0010);
    beat(2'd1, 22'd1000, 1'b0, 22'd0,   1'b0,    1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("location_hold", rpeak_location, 1000);
    beat(2'd1, 22'd1400, 1'b1, 22'd400, 1'b0,    1'b0, 1'b0);
    beat(2'd1, 22'd1820, 1'b1, 22'd420, 1'b0,    1'b0, 1'b0);
    beat(2'd1, 22'd2420, 1'b1, 22'd600, OUTLIER, 1'b0, 1'b0);
    check("rr_period_hold", rr_period, 600);

    // 4: ch0 beats interleaved with flat ch2, a few ch3 noise samples
    do_reset();
    send(2'd3, 300, 22'd5);
    send(2'd3, -200, 22'd6);
    send(2'd3, 77, 22'd7);
    train(2'd0, 1'b1);
    beat(2'd0, 22'd500, 1'b0, 22'd0,   1'b0, 1'b1, 1'b0);
    beat(2'd0, 22'd800, 1'b1, 22'd300, 1'b0, 1'b1, 1'b0);
    check("iso_alg_active", alg_active, 4'b0101);
    check("iso_th_init", th_init, 4'b0101);

    // 5: counter wrap between peaks, spike during refractory ignored
    do_reset();
    train(2'd3, 1'b0);
    beat(2'd3, 22'd4194204, 1'b0, 22'd0,   1'b0, 1'b0, 1'b1);
    beat(2'd3, 22'd50,      1'b1, 22'd150, 1'b0, 1'b0, 1'b0);
    check("wrap_th_init", th_init, 4'b1000);
    check("final_irregular", rr_irregular, 0);

    repeat (4) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
